cva6_pma_region_table: RTL

// - Runtime-programmable PMA table: NR_RULES base/length regions, each with attributes {X, C, NI}.
// - Reset contents come from the compile-time region tables of the config package.
// - Serves NR_LKP independent lookup channels (fetch, load/store) with a 1-cycle registered pipeline.
// - Sits between the frontend/LSU and the cache subsystem; replaces the static region decode.

---
 rtl/cva6_pma_region_table.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cva6_pma_region_table.sv
// cva6_pma_region_table: runtime-programmable PMA region table.
// A shadow table is written through the config port and copied into the active
// table on commit_i. NR_LKP independent lookup channels match against the
// active table through a one-entry registered result stage.
// Optional feature: define CVA6_PMA_MISS_CNT_EN to add per-channel 16-bit
// saturating miss counters on port miss_cnt_o.
module cva6_pma_region_table #(
   parameter int unsigned NR_RULES = 4,
   parameter int unsigned NR_LKP   = 2,
   parameter int unsigned ADDR_W   = 64,
   // Derived index width; leave at its default.
   parameter int unsigned IDX_W    = (NR_RULES > 1) ? $clog2(NR_RULES) : 1,
   parameter logic [NR_RULES-1:0][ADDR_W-1:0] RST_BASE = '0,
   parameter logic [NR_RULES-1:0][ADDR_W-1:0] RST_LEN  = '0,
   parameter logic [NR_RULES-1:0][3:0]        RST_ATTR = {NR_RULES{4'b0001}}
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       cfg_req_i,
   input  logic                       cfg_we_i,
   input  logic [IDX_W-1:0]           cfg_idx_i,
   input  logic [1:0]                 cfg_field_i,
   input  logic [ADDR_W-1:0]          cfg_wdata_i,
   output logic                       cfg_gnt_o,
   output logic                       cfg_rvalid_o,
   output logic [ADDR_W-1:0]          cfg_rdata_o,
   output logic                       cfg_err_o,
   input  logic                       commit_i,
   input  logic [NR_LKP-1:0]          lkp_valid_i,
   output logic [NR_LKP-1:0]          lkp_ready_o,
   input  logic [NR_LKP*ADDR_W-1:0]   lkp_addr_i,
   output logic [NR_LKP-1:0]          lkp_rvalid_o,
   input  logic [NR_LKP-1:0]          lkp_rready_i,
   output logic [NR_LKP*3-1:0]        lkp_attr_o,
   output logic [NR_LKP-1:0]          lkp_hit_o,
   output logic [NR_LKP*IDX_W-1:0]    lkp_idx_o
`ifdef CVA6_PMA_MISS_CNT_EN
   ,
   output logic [NR_LKP*16-1:0]       miss_cnt_o
`endif
);

   // Shadow table (config-visible, carries lock bit) and active table (lookups).
   logic [NR_RULES-1:0][ADDR_W-1:0] sh_base_q, sh_len_q;
   logic [NR_RULES-1:0][3:0]        sh_attr_q;
   logic [NR_RULES-1:0][ADDR_W-1:0] ac_base_q, ac_len_q;
   logic [NR_RULES-1:0][2:0]        ac_attr_q;

   logic              idx_ok;
   logic              cfg_err_d;
   logic              cfg_wr_en;
   logic [ADDR_W-1:0] cfg_rdata_d;
   logic              cfg_rvalid_q, cfg_err_q;
   logic [ADDR_W-1:0] cfg_rdata_q;

   // Index range check is only needed when the index can encode unused rules.
   if ((2 ** IDX_W) > NR_RULES) begin : g_idx_chk
      assign idx_ok = (cfg_idx_i < IDX_W'(NR_RULES));
   end else begin : g_idx_all
      assign idx_ok = 1'b1;
   end

   assign cfg_gnt_o = cfg_req_i;
   assign cfg_err_d = !idx_ok || (cfg_field_i == 2'd3) ||
                      (cfg_we_i && idx_ok && sh_attr_q[cfg_idx_i][3]);
   assign cfg_wr_en = cfg_req_i && cfg_we_i && !cfg_err_d;

   // Config read mux from the shadow table; errors and writes return zero.
   always_comb begin
      cfg_rdata_d = '0;
      if (cfg_req_i && !cfg_we_i && !cfg_err_d) begin
         case (cfg_field_i)
            2'd0:    cfg_rdata_d = sh_base_q[cfg_idx_i];
            2'd1:    cfg_rdata_d = sh_len_q[cfg_idx_i];
            2'd2:    cfg_rdata_d = ADDR_W'(sh_attr_q[cfg_idx_i]);
            default: cfg_rdata_d = '0;
         endcase
      end
   end

   // Table storage: commit copies the pre-edge shadow, so a same-cycle write lands after it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sh_base_q <= RST_BASE;
         sh_len_q  <= RST_LEN;
         sh_attr_q <= RST_ATTR;
         ac_base_q <= RST_BASE;
         ac_len_q  <= RST_LEN;
         for (int r = 0; r < int'(NR_RULES); r++) ac_attr_q[r] <= RST_ATTR[r][2:0];
      end else begin
         if (commit_i) begin
            ac_base_q <= sh_base_q;
            ac_len_q  <= sh_len_q;
            for (int r = 0; r < int'(NR_RULES); r++) ac_attr_q[r] <= sh_attr_q[r][2:0];
         end
         if (cfg_wr_en) begin
            case (cfg_field_i)
               2'd0:    sh_base_q[cfg_idx_i] <= cfg_wdata_i;
               2'd1:    sh_len_q[cfg_idx_i]  <= cfg_wdata_i;
               2'd2:    sh_attr_q[cfg_idx_i] <= {sh_attr_q[cfg_idx_i][3] | cfg_wdata_i[3],
                                                 cfg_wdata_i[2:0]};
               default: ;
            endcase
         end
      end
   end

   // Config response register, one cycle after the grant.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cfg_rvalid_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         cfg_rdata_q  <= '0;
      end else begin
         cfg_rvalid_q <= cfg_req_i;
         cfg_err_q    <= cfg_req_i && cfg_err_d;
         cfg_rdata_q  <= cfg_rdata_d;
      end
   end

   assign cfg_rvalid_o = cfg_rvalid_q;
   assign cfg_err_o    = cfg_err_q;
   assign cfg_rdata_o  = cfg_rdata_q;

   for (genvar ch = 0; ch < int'(NR_LKP); ch++) begin : g_ch
      logic [ADDR_W-1:0] addr;
      logic              m_hit;
      logic [IDX_W-1:0]  m_idx;
      logic [2:0]        m_attr;
      logic              accept;
      logic              rvalid_q, hit_q;
      logic [IDX_W-1:0]  idx_q;
      logic [2:0]        attr_q;

      assign addr   = lkp_addr_i[ch*ADDR_W +: ADDR_W];
      assign accept = lkp_valid_i[ch] && lkp_ready_o[ch];

      // Region match against the active table; scanning downward lets the lowest index win.
      always_comb begin
         logic [ADDR_W:0] diff;
         diff   = '0;
         m_hit  = 1'b0;
         m_idx  = '0;
         m_attr = 3'b001;
         for (int r = int'(NR_RULES) - 1; r >= 0; r--) begin
            // The extra bit catches addr < base as a borrow instead of wrapping.
            diff = {1'b0, addr} - {1'b0, ac_base_q[r]};
            if ((ac_len_q[r] != '0) && !diff[ADDR_W] && (diff[ADDR_W-1:0] < ac_len_q[r])) begin
               m_hit  = 1'b1;
               m_idx  = IDX_W'(r);
               m_attr = ac_attr_q[r];
            end
         end
      end

      // Result register: load on accept, drop valid when consumed, otherwise hold.
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            rvalid_q <= 1'b0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
            attr_q   <= '0;
         end else if (accept) begin
            rvalid_q <= 1'b1;
            hit_q    <= m_hit;
            idx_q    <= m_idx;
            attr_q   <= m_attr;
         end else if (lkp_rready_i[ch]) begin
            rvalid_q <= 1'b0;
         end
      end

      assign lkp_ready_o[ch]              = !rvalid_q || lkp_rready_i[ch];
      assign lkp_rvalid_o[ch]             = rvalid_q;
      assign lkp_hit_o[ch]                = hit_q;
      assign lkp_idx_o[ch*IDX_W +: IDX_W] = idx_q;
      assign lkp_attr_o[ch*3 +: 3]        = attr_q;

`ifdef CVA6_PMA_MISS_CNT_EN
      logic [15:0] miss_q;

      // Saturating miss counter; commit clears it ahead of any same-cycle increment.
      always_ff @(posedge clk_i) begin
         if (!rst_ni || commit_i) begin
            miss_q <= '0;
         end else if (accept && !m_hit && (miss_q != 16'hFFFF)) begin
            miss_q <= miss_q + 16'd1;
         end
      end

      assign miss_cnt_o[ch*16 +: 16] = miss_q;
`endif
   end

endmodule
